// File: rtl/fractal_pkg.sv
// Shared types and the iteration-count colormap for the fractal pixel path.
package fractal_pkg;

    localparam int MAX_ITER = 255;

    typedef logic [23:0] rgb888_t;

    typedef struct packed {
        rgb888_t data;
        logic    user;
        logic    last;
    } pixel_beat_t;

    // Points inside the set render black; everything else gets a simple ramp palette.
    function automatic rgb888_t colormap(input logic [7:0] iter, input logic [7:0] max_iter);
        if (iter == max_iter) begin
            return 24'h000000;
        end
        return {iter, iter[6:0], 1'b0, ~iter};
    endfunction

endpackage

// File: rtl/fractal_stream_sink_fifo.sv
// Synchronous FIFO with flop-held head, full flag and synchronous flush on reset.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_valid;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_next;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_pop        = i_rd_en && r_valid;
    assign o_full       = (r_count == FULL_CNT);
    assign w_push       = i_wr_en && (!o_full || w_pop);
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_valid   = r_valid;
    assign o_rd_data = r_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fractal_stream_sink.sv
// Receives the fractal pixel stream, checks framing, colormaps, and buffers for an AXIS consumer.
module fractal_stream_sink #(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_ITER   = fractal_pkg::MAX_ITER
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [7:0]  s_data,
    input  logic        s_user,
    input  logic        s_last,
    input  logic        s_valid,
    output logic [23:0] m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    input  logic        status_clear,
    output logic        sof_err,
    output logic        eol_err,
    output logic        overflow,
    output logic [15:0] frame_count
);
    import fractal_pkg::*;

    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_frame_count;
    logic        r_synced;
    logic        r_s1_valid;
    pixel_beat_t r_s1_beat;
    logic        r_sof_err;
    logic        r_eol_err;
    logic        r_overflow;

    logic        w_accept;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_x_end;
    logic        w_y_end;
    logic        w_eol;
    logic        w_sof_set;
    logic        w_eol_set;
    logic        w_ovf_set;
    logic        w_full;
    pixel_beat_t w_head;

    // A frame-start beat is always pixel (0,0), whatever the counters say.
    assign w_accept  = s_valid && (r_synced || s_user);
    assign w_x       = s_user ? 16'd0 : r_x;
    assign w_y       = s_user ? 16'd0 : r_y;
    assign w_x_end   = (w_x == r_width - 16'd1);
    assign w_y_end   = (w_y == r_height - 16'd1);
    assign w_eol     = w_x_end || s_last;
    assign w_sof_set = w_accept && s_user && r_synced && ((r_x != 16'd0) || (r_y != 16'd0));
    assign w_eol_set = w_accept && (w_x_end != s_last);
    assign w_ovf_set = r_s1_valid && w_full && !(m_tvalid && m_tready);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_width       <= width;
            r_height      <= height;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_count <= '0;
            r_synced      <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_beat     <= '0;
            r_sof_err     <= 1'b0;
            r_eol_err     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_synced  <= 1'b1;
                r_s1_beat <= '{data: colormap(s_data, 8'(MAX_ITER)),
                               user: (w_x == 16'd0) && (w_y == 16'd0),
                               last: w_eol};
                if (w_eol) begin
                    r_x <= '0;
                    if (w_y_end) begin
                        r_y           <= '0;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else begin
                        r_y <= w_y + 16'd1;
                    end
                end else begin
                    r_x <= w_x + 16'd1;
                    r_y <= w_y;
                end
            end
            r_sof_err  <= w_sof_set | (r_sof_err  & ~status_clear);
            r_eol_err  <= w_eol_set | (r_eol_err  & ~status_clear);
            r_overflow <= w_ovf_set | (r_overflow & ~status_clear);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pixel_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (r_s1_valid),
        .i_wr_data (r_s1_beat),
        .i_rd_en   (m_tready),
        .o_rd_data (w_head),
        .o_valid   (m_tvalid),
        .o_full    (w_full)
    );

    assign m_tdata     = w_head.data;
    assign m_tuser     = w_head.user;
    assign m_tlast     = w_head.last;
    assign sof_err     = r_sof_err;
    assign eol_err     = r_eol_err;
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fractal_stream_sink.sv
// Scoreboard bench for fractal_stream_sink: reference model feeds exp_q, monitor compares outputs.
module tb_fractal_stream_sink;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] width = 16'd4;
    logic [15:0] height = 16'd2;
    logic [7:0]  s_data = '0;
    logic        s_user = 1'b0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        status_clear = 1'b0;
    logic        sof_err;
    logic        eol_err;
    logic        overflow;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    fractal_stream_sink #(.FIFO_DEPTH(DEPTH), .MAX_ITER(255)) dut (
        .clk(clk), .resetn(resetn), .width(width), .height(height),
        .s_data(s_data), .s_user(s_user), .s_last(s_last), .s_valid(s_valid),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .status_clear(status_clear),
        .sof_err(sof_err), .eol_err(eol_err), .overflow(overflow),
        .frame_count(frame_count)
    );

    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 0;
    bit rand_ready_en = 0;

    // Reference model state: frame geometry, raster position, pending beat, flags.
    int m_w, m_h, m_x, m_y, m_frames;
    bit m_synced, m_pend, m_sof, m_eol, m_ovf;
    logic [25:0] m_pend_beat;

    function automatic logic [23:0] ref_color(input int it);
        if (it == 255) return 24'h000000;
        return 24'((it << 16) | (((it * 2) % 256) << 8) | (255 - it));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin : model
        int px, py;
        bit cnt_end, eol, sof_set, eol_set, ovf_set;
        @(posedge clk);
        if (!resetn) begin
            m_w = int'(width); m_h = int'(height);
            m_x = 0; m_y = 0; m_frames = 0;
            m_synced = 0; m_pend = 0; m_sof = 0; m_eol = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            sof_set = 0; eol_set = 0; ovf_set = 0;
            if (m_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_beat);
                else ovf_set = 1;
            end
            m_pend = 0;
            if (s_valid && (m_synced || s_user)) begin
                px = s_user ? 0 : m_x;
                py = s_user ? 0 : m_y;
                cnt_end = (px == m_w - 1);
                eol = cnt_end || s_last;
                sof_set = s_user && m_synced && (m_x != 0 || m_y != 0);
                eol_set = (cnt_end != s_last);
                m_synced = 1;
                m_pend = 1;
                m_pend_beat = {ref_color(int'(s_data)), (px == 0 && py == 0), eol};
                if (eol) begin
                    m_x = 0;
                    if (py == m_h - 1) begin
                        m_y = 0;
                        m_frames = (m_frames + 1) % 65536;
                    end else begin
                        m_y = py + 1;
                    end
                end else begin
                    m_x = px + 1;
                    m_y = py;
                end
            end
            m_sof = sof_set ? 1'b1 : (status_clear ? 1'b0 : m_sof);
            m_eol = eol_set ? 1'b1 : (status_clear ? 1'b0 : m_eol);
            m_ovf = ovf_set ? 1'b1 : (status_clear ? 1'b0 : m_ovf);
        end
    end

    initial forever begin : monitor
        @(negedge clk);
        if (mon_en) begin
            check("m_tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
            if (m_tvalid && exp_q.size() != 0) begin
                check("beat", 32'({m_tdata, m_tuser, m_tlast}), 32'(exp_q[0]));
                if (m_tready) begin
                    got_q.push_back({m_tdata, m_tuser, m_tlast});
                    void'(exp_q.pop_front());
                end
            end
            check("flags", 32'({sof_err, eol_err, overflow}), 32'({m_sof, m_eol, m_ovf}));
            check("frame_count", 32'(frame_count), 32'(m_frames));
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready_en) m_tready = 1'($urandom_range(0, 1));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [7:0] d, input logic u, input logic l);
        s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_reset(input int w, input int h);
        width = 16'(w); height = 16'(h);
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || m_pend) && k < 300) begin tick(); k++; end
        tick(2);
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        status_clear = 1'b1; tick(); status_clear = 1'b0;
    endtask

    initial begin : stimulus
        logic [25:0] b;
        logic [7:0] uv, lv;
        int w, h, tx, ty;
        bit u, l;

        // Reset state and a clean 4x2 frame.
        do_reset(4, 2);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_flags", 32'({sof_err, eol_err, overflow}), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        mon_en = 1;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            beat(8'(i), i == 0, (i % 4) == 3);
            if (i == 0) check("lat_not_yet", 32'(m_tvalid), 32'd0);
            if (i == 1) begin
                check("lat_valid", 32'(m_tvalid), 32'd1);
                check("lat_data", 32'(m_tdata), 32'h0000FF);
            end
        end
        drain();
        check("t1_count", 32'(got_q.size()), 32'd8);
        uv = '0; lv = '0;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            b = got_q[i]; uv[i] = b[1]; lv[i] = b[0];
        end
        check("t1_user", 32'(uv), 32'h01);
        check("t1_last", 32'(lv), 32'h88);
        b = got_q[0]; check("t1_beat0", 32'(b[25:2]), 32'h0000FF);
        b = got_q[1]; check("t1_beat1", 32'(b[25:2]), 32'h0102FE);
        check("t1_frames", 32'(frame_count), 32'd1);
        check("t1_flags", 32'({sof_err, eol_err, overflow}), 32'd0);

        // Colormap edges.
        got_q.delete();
        beat(8'd255, 1'b1, 1'b0);
        beat(8'd128, 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) beat(8'($urandom_range(0, 255)), 1'b0, (i % 4) == 3);
        drain();
        b = got_q[0]; check("cmap_255", 32'(b[25:2]), 32'h000000);
        b = got_q[1]; check("cmap_128", 32'(b[25:2]), 32'h80007F);
        check("t2_frames", 32'(frame_count), 32'd2);

        // Early tlast on x=2.
        got_q.delete();
        beat(8'd1, 1'b1, 1'b0); beat(8'd2, 1'b0, 1'b0); beat(8'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) beat(8'(4 + i), 1'b0, i == 3);
        drain();
        check("early_eol_err", 32'(eol_err), 32'd1);
        check("early_count", 32'(got_q.size()), 32'd7);
        b = got_q[2]; check("early_last", 32'(b[0]), 32'd1);
        b = got_q[3]; check("early_next_flags", 32'(b[1:0]), 32'd0);
        check("early_frames", 32'(frame_count), 32'd3);
        pulse_clear();
        check("early_clear", 32'(eol_err), 32'd0);

        // Mid-frame start, then resync inside a line.
        do_reset(4, 2);
        got_q.delete();
        beat(8'd5, 1'b0, 1'b0); beat(8'd6, 1'b0, 1'b0); beat(8'd7, 1'b0, 1'b1);
        tick(4);
        check("unsync_out", 32'(got_q.size()), 32'd0);
        check("unsync_flags", 32'({sof_err, eol_err, overflow}), 32'd0);
        beat(8'd10, 1'b1, 1'b0); beat(8'd11, 1'b0, 1'b0); beat(8'd12, 1'b1, 1'b0);
        tick(3);
        check("resync_flags", 32'({sof_err, eol_err, overflow}), 32'b100);
        check("resync_count", 32'(got_q.size()), 32'd3);
        b = got_q[2]; check("resync_user", 32'(b[1]), 32'd1);
        pulse_clear();

        // Overflow with the output stalled.
        do_reset(4, 2);
        m_tready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 6; i++) beat(8'(20 + i), i == 0, i == 3);
        tick(4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_valid", 32'(m_tvalid), 32'd1);
        check("ovf_head", 32'(m_tdata), 32'(ref_color(20)));
        tick(5);
        m_tready = 1'b1;
        drain();
        check("ovf_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            b = got_q[i];
            check("ovf_order", 32'(b[25:2]), 32'(ref_color(20 + i)));
        end

        // Reset mid-frame with the FIFO half full; new geometry takes effect.
        m_tready = 1'b0;
        beat(8'd30, 1'b1, 1'b0); beat(8'd31, 1'b0, 1'b0);
        tick(2);
        check("pre_rst_valid", 32'(m_tvalid), 32'd1);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        width = 16'd3; height = 16'd1; resetn = 1'b0;
        tick();
        check("mid_rst_valid", 32'(m_tvalid), 32'd0);
        check("mid_rst_flags", 32'({sof_err, eol_err, overflow}), 32'd0);
        check("mid_rst_frames", 32'(frame_count), 32'd0);
        tick();
        resetn = 1'b1;
        m_tready = 1'b1;
        got_q.delete();
        beat(8'd40, 1'b1, 1'b0); beat(8'd41, 1'b0, 1'b0); beat(8'd42, 1'b0, 1'b1);
        drain();
        check("neww_count", 32'(got_q.size()), 32'd3);
        b = got_q[2]; check("neww_last", 32'(b[0]), 32'd1);
        check("neww_eol_err", 32'(eol_err), 32'd0);
        check("neww_frames", 32'(frame_count), 32'd1);

        // Randomized framing, gaps, errors, backpressure and clears.
        for (int run = 0; run < 4; run++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 3);
            do_reset(w, h);
            rand_ready_en = 1;
            tx = $urandom_range(0, w - 1);
            ty = 0;
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
                u = (tx == 0 && ty == 0);
                l = (tx == w - 1);
                if ($urandom_range(0, 19) == 0) u = ~u;
                if ($urandom_range(0, 19) == 0) l = ~l;
                status_clear = ($urandom_range(0, 15) == 0);
                beat(8'($urandom_range(0, 255)), u, l);
                status_clear = 1'b0;
                if (tx == w - 1) begin
                    tx = 0;
                    ty = (ty == h - 1) ? 0 : ty + 1;
                end else begin
                    tx++;
                end
            end
            rand_ready_en = 0;
            tick();
            m_tready = 1'b1;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fractal_stream_sink.md
Name: fractal_stream_sink

Overview:
Receiving end of the fractal generator's 8-bit pixel stream (tdata/tuser/tlast/tvalid, no tready).
- Checks framing against the programmed width/height.
- Maps iteration counts to RGB888.
- Buffers pixels in a FIFO so a backpressured AXI4-Stream video consumer (VDMA / video out) can drain them.
- Reports framing errors and overflow as sticky status.

Parameters:
FIFO_DEPTH, 64, FIFO entries; power of two, >= 4.
MAX_ITER, 255, iteration value that means "inside set"; colormaps to black.

Ports:
clk  in  1  clock
resetn  in  1  reset
width  in  16  frame width in pixels; sampled only while resetn low
height  in  16  frame height in lines; sampled only while resetn low
s_data  in  8  pixel iteration count (tdata)
s_user  in  1  frame start (tuser)
s_last  in  1  line end (tlast)
s_valid  in  1  beat valid (tvalid); no backpressure possible
m_tdata  out  24  RGB888, {R,G,B}
m_tuser  out  1  first pixel of frame
m_tlast  out  1  last pixel of line
m_tvalid  out  1  output valid
m_tready  in  1  output ready
status_clear  in  1  one-cycle pulse, clears sticky flags
sof_err  out  1  sticky: s_user at position other than (0,0)
eol_err  out  1  sticky: s_last missing or early
overflow  out  1  sticky: beat dropped because FIFO full
frame_count  out  16  completed frames since reset, wraps

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. While resetn low:
  - width/height latch into width_i/height_i.
  - Counters zero, synced=0, FIFO empty.
  - All outputs 0.
- Sync: after reset, beats are discarded until the first beat with s_user=1; that beat sets synced=1 and is pixel (0,0). No error flags are raised while unsynced.
- Position counters in_x/in_y, advanced on each accepted beat (s_valid && synced-after-update):
  - s_user=1: treated as (0,0) regardless of counters. If the counters were not at (0,0) and synced was already 1, set sof_err (resync).
  - End of line is in_x==width_i-1 or s_last=1.
  - Mismatch between the two conditions sets eol_err. On either condition, in_x wraps to 0; in_y increments, or wraps to 0 at height_i-1.
  - Wrap from (width_i-1, height_i-1) increments frame_count.
- Output flags are regenerated from position, not copied from input:
  - tuser = (pos==(0,0)).
  - tlast = end of line per the rule above.
- Colormap, stage 1, registered:
  - iter==MAX_ITER: 0x000000.
  - Otherwise R=iter, G={iter[6:0],1'b0}, B=~iter.
- FIFO write, stage 2: the colormapped beat is written in the cycle after the input beat.
  - If full, the beat is dropped and overflow is set. Position counters still advance, so framing stays consistent.
- FIFO read: registered output, standard AXIS.
  - m_tvalid rises the cycle after the write into an empty FIFO, giving 2 cycles of input-to-output latency.
  - Data holds stable while m_tvalid && !m_tready.
  - Pop on m_tvalid && m_tready.
  - Simultaneous push and pop at full succeeds with no drop.
- Sticky flags: set has priority over status_clear in the same cycle.
- Reset mid-frame: everything flushes, including FIFO contents and pending m_tvalid. The next frame requires a new s_user.

Decomposition:
- fractal_pkg:
  - MAX_ITER.
  - rgb888_t typedef.
  - pixel_beat_t struct {rgb888_t data; logic user; logic last}.
  - colormap function iter->rgb888_t, shared with any future palette logic.
- Sub-module sync_fifo: parameterized width/depth, registered output, full/empty, reset flush. Stores pixel_beat_t, 26 bits.

Test Plan:
- Clean frame, width=4 height=2, data 0..7, m_tready=1:
  - 8 output beats, 2 cycles after each input.
  - m_tuser only on beat 0; m_tlast on beats 3 and 7.
  - Beat 0 = 0x0000FF; beat 1 = 0x0102FE.
  - frame_count=1; no flags.
- Colormap edge: s_data=255 -> 0x000000; s_data=128 -> 0x8000_7F.
- Early tlast, width=4: s_last on in_x=2 -> eol_err=1.
  - The next beat outputs as (0,1) with m_tlast on the early beat.
  - status_clear then drops eol_err.
- Mid-frame start: stream begins at pixel 5 of a 4x2 frame -> no output, no flags until the next s_user; s_user at in_x=2 after sync -> sof_err=1.
- Overflow, FIFO_DEPTH=4, m_tready=0, 6 beats:
  - 4 stored, overflow=1.
  - Release m_tready -> exactly those 4 emitted in order, data held stable while stalled.
- Reset asserted mid-frame with FIFO half full -> m_tvalid=0 next cycle, flags 0, frame_count=0; new width latched and used for the next frame.
